uart_xcvr: RTL and testbench
============================

UART_XCVR -- requirements
Module: uart_xcvr

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, 87, clock cycles per bit (>=4).
REQ-002 SHALL have parameter DATA_BITS, 8, data bits per frame (5..8).
REQ-003 SHALL have parameter PARITY_MODE, 0, 0 none / 1 odd / 2 even.
REQ-004 SHALL have parameter STOP_BITS, 1, stop bits per frame (1 or 2).
REQ-005 SHALL have parameter RX_FIFO_DEPTH, 4, RX entries (power of 2, >=2).
REQ-006 SHALL have port i_Clock  in  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port i_Reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have ports i_Tx_DV in 1 (TX request) and i_Tx_Byte in DATA_BITS (TX data).
REQ-009 SHALL have ports o_Tx_Active out 1, o_Tx_Serial out 1 (line, idle high) and o_Tx_Done out 1 (frame-complete pulse).
REQ-010 SHALL have ports i_Rx_Serial in 1 (async line) and i_Rx_Rd in 1 (pop).
REQ-011 SHALL have ports o_Rx_DV out 1, o_Rx_Byte out DATA_BITS, o_Rx_Parity_Err out 1, o_Rx_Frame_Err out 1 and o_Rx_Overrun out 1.

Function
REQ-012 TX SHALL use FSM IDLE->START->DATA->PARITY->STOP->CLEANUP->IDLE; PARITY skipped when PARITY_MODE=0.
REQ-013 TX SHALL accept i_Tx_DV only in IDLE, latching i_Tx_Byte; i_Tx_DV while active SHALL be ignored.
REQ-014 TX SHALL drive start bit low the cycle after accept; each bit lasts exactly CLKS_PER_BIT cycles; data LSB first.
REQ-015 Parity bit SHALL be XOR of data (even) or its inverse (odd); STOP_BITS high bits follow.
REQ-016 o_Tx_Active SHALL be high from start-bit cycle through last stop-bit cycle; o_Tx_Done SHALL pulse one cycle in CLEANUP.
REQ-017 Back-to-back: i_Tx_DV in the cycle after o_Tx_Done SHALL be accepted.
REQ-018 i_Rx_Serial SHALL pass a 2-flop synchroniser (both flops reset to 1) before use.
REQ-019 RX SHALL use FSM IDLE->START->DATA->PARITY->STOP->IDLE, leaving IDLE on a synchronised high-to-low edge.
REQ-020 RX SHALL re-sample start bit after CLKS_PER_BIT/2 cycles; if high, false start, return to IDLE, nothing stored.
REQ-021 RX SHALL sample each subsequent bit every CLKS_PER_BIT cycles from the start mid-point.
REQ-022 Parity mismatch SHALL set the entry's parity-error flag; any stop bit sampled low SHALL set its frame-error flag.
REQ-023 Errored frames SHALL still be stored, with flags presented on o_Rx_Parity_Err/o_Rx_Frame_Err alongside o_Rx_Byte.
REQ-024 RX SHALL return to IDLE after the last stop-bit sample and accept a new start edge the following cycle.

Reset
REQ-025 On i_Reset at a rising edge both FSMs SHALL enter IDLE, counters clear, mid-frame data discarded.
REQ-026 Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=0, all error/overrun outputs 0, FIFO empty.

Configuration
REQ-027 Macro UART_RX_FIFO_EN defined: received frames SHALL enter an RX_FIFO_DEPTH FIFO of {data,perr,ferr}; o_Rx_DV = not empty; outputs show head; i_Rx_Rd with o_Rx_DV pops one entry; i_Rx_Rd when empty ignored.
REQ-028 With FIFO: write when full SHALL drop the frame and pulse o_Rx_Overrun one cycle; simultaneous pop and write when full SHALL accept the write.
REQ-029 Macro undefined: single holding register; o_Rx_DV SHALL pulse one cycle per frame, data/flags held until next frame; i_Rx_Rd ignored; o_Rx_Overrun tied 0.

Structure
REQ-030 Package uart_pkg SHALL hold TX/RX state enums and PARITY_NONE/ODD/EVEN constants.
REQ-031 FIFO SHALL be sub-module uart_rx_fifo (synchronous, count-based full/empty, pointer wrap modulo depth).

Verification
REQ-032 10 MHz clock, defaults: i_Tx_DV with 8'hAB -> line 0,1,1,0,1,0,1,0,1,1 each 8700 ns; o_Tx_Done one pulse.
REQ-033 Drive 8'h3F on i_Rx_Serial, bit period 8700 ns -> o_Rx_DV, o_Rx_Byte=8'h3F, no error flags.
REQ-034 PARITY_MODE=2, 8'h07 sent with parity 0 -> stored byte 8'h07 with o_Rx_Parity_Err=1.
REQ-035 FIFO on, depth 4: send 5 frames 8'h01..8'h05 without pop -> o_Rx_Overrun pulse on 5th; pops yield 8'h01..8'h04.
REQ-036 2000 ns low glitch on i_Rx_Serial -> false start, no o_Rx_DV; 8'h55 with stop bit low -> o_Rx_Frame_Err=1.
REQ-037 i_Reset asserted mid-TX frame -> o_Tx_Serial=1, o_Tx_Active=0 next cycle; no o_Tx_Done.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encodings and parity-mode constants for uart_xcvr.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_CLEANUP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: count-based synchronous FIFO for received frames.
// Ports: clk/rst (sync active-high), wr/din push, rd pop, dout head entry,
// empty flag, overrun one-cycle pulse when a push is dropped.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      count;
    logic             full, rd_ok, wr_ok;

    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);
    assign rd_ok = rd & ~empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign wr_ok = wr & (~full | rd_ok);
    assign dout  = mem[rp];

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            wp      <= wp + AW'(wr_ok);
            rp      <= rp + AW'(rd_ok);
            count   <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
            overrun <= wr & ~wr_ok;
        end
    end
endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transmitter/receiver with optional RX FIFO.
// Ports: i_Clock, i_Reset (sync active-high); TX: i_Tx_DV/i_Tx_Byte request,
// o_Tx_Active, o_Tx_Serial (idle high), o_Tx_Done pulse; RX: i_Rx_Serial async
// line, i_Rx_Rd pop, o_Rx_DV, o_Rx_Byte, o_Rx_Parity_Err, o_Rx_Frame_Err, o_Rx_Overrun.
// Macro UART_RX_FIFO_EN: buffer frames in uart_rx_fifo; otherwise a single
// holding register with a one-cycle o_Rx_DV pulse per frame.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 87,
    parameter int DATA_BITS     = 8,
    parameter int PARITY_MODE   = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Done,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Rx_Rd,
    output logic                 o_Rx_DV,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Parity_Err,
    output logic                 o_Rx_Frame_Err,
    output logic                 o_Rx_Overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic ODD = PARITY_MODE == PARITY_ODD;

    tx_state_t            tx_state, tx_next;
    logic [CW-1:0]        tx_cnt;
    logic [2:0]           tx_idx;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_tick;

    assign tx_tick = tx_cnt == BIT_END;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == TX_IDLE || tx_tick || tx_next != tx_state) ? '0 : tx_cnt + 1'b1;
            tx_idx   <= (tx_next != tx_state) ? '0 : tx_idx + 3'(tx_tick);
            if (tx_state == TX_IDLE && i_Tx_DV) begin
                tx_shift <= i_Tx_Byte;
                tx_par   <= (^i_Tx_Byte) ^ ODD;
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= tx_shift >> 1;
            end
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (i_Tx_DV) tx_next = TX_START;
            TX_START:  if (tx_tick) tx_next = TX_DATA;
            TX_DATA:   if (tx_tick && tx_idx == 3'(DATA_BITS - 1))
                           tx_next = (PARITY_MODE == PARITY_NONE) ? TX_STOP : TX_PARITY;
            TX_PARITY: if (tx_tick) tx_next = TX_STOP;
            TX_STOP:   if (tx_tick && tx_idx == 3'(STOP_BITS - 1)) tx_next = TX_CLEANUP;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        o_Tx_Serial = tx_state == TX_START  ? 1'b0 :
                      tx_state == TX_DATA   ? tx_shift[0] :
                      tx_state == TX_PARITY ? tx_par : 1'b1;
        o_Tx_Active = tx_state inside {TX_START, TX_DATA, TX_PARITY, TX_STOP};
        o_Tx_Done   = tx_state == TX_CLEANUP;
    end

    logic [1:0]           rx_sync;
    logic                 rx, rx_prev, rx_tick, rx_perr, rx_ferr, rx_wr;
    rx_state_t            rx_state, rx_next;
    logic [CW-1:0]        rx_cnt;
    logic [2:0]           rx_idx;
    logic [DATA_BITS-1:0] rx_shift;
    logic [DATA_BITS+1:0] rx_word;

    assign rx      = rx_sync[1];
    // The start bit is re-checked at its half point; later bits are a full period apart.
    assign rx_tick = (rx_state == RX_START) ? rx_cnt == HALF_END : rx_cnt == BIT_END;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], i_Rx_Serial};
            rx_prev  <= rx;
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == RX_IDLE || rx_tick) ? '0 : rx_cnt + 1'b1;
            rx_idx   <= (rx_next != rx_state) ? '0 : rx_idx + 3'(rx_tick);
            if (rx_state == RX_START) begin
                rx_perr <= 1'b0;
                rx_ferr <= 1'b0;
            end
            if (rx_state == RX_DATA && rx_tick) rx_shift <= {rx, rx_shift[DATA_BITS-1:1]};
            if (rx_state == RX_PARITY && rx_tick) rx_perr <= rx ^ (^rx_shift) ^ ODD;
            if (rx_state == RX_STOP && rx_tick && !rx) rx_ferr <= 1'b1;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_prev && !rx) rx_next = RX_START;
            RX_START:  if (rx_tick) rx_next = rx ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_idx == 3'(DATA_BITS - 1))
                           rx_next = (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
            RX_PARITY: if (rx_tick) rx_next = RX_STOP;
            RX_STOP:   if (rx_tick && rx_idx == 3'(STOP_BITS - 1)) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_wr   = rx_state == RX_STOP && rx_tick && rx_idx == 3'(STOP_BITS - 1);
        // The final stop sample is folded in directly since rx_ferr updates a cycle late.
        rx_word = {rx_shift, rx_perr, rx_ferr | ~rx};
    end

`ifdef UART_RX_FIFO_EN
    logic [DATA_BITS+1:0] head;
    logic                 empty;

    uart_rx_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(RX_FIFO_DEPTH)) u_fifo (
        .clk(i_Clock), .rst(i_Reset), .wr(rx_wr), .din(rx_word),
        .rd(i_Rx_Rd), .dout(head), .empty(empty), .overrun(o_Rx_Overrun)
    );

    assign o_Rx_DV = ~empty;
    assign {o_Rx_Byte, o_Rx_Parity_Err, o_Rx_Frame_Err} = empty ? '0 : head;
`else
    logic [DATA_BITS+1:0] hold;
    logic                 dv;
    logic                 unused_rd;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            hold <= '0;
            dv   <= 1'b0;
        end else begin
            dv <= rx_wr;
            if (rx_wr) hold <= rx_word;
        end
    end

    assign o_Rx_DV      = dv;
    assign {o_Rx_Byte, o_Rx_Parity_Err, o_Rx_Frame_Err} = hold;
    assign o_Rx_Overrun = 1'b0;
    assign unused_rd    = i_Rx_Rd & (RX_FIFO_DEPTH > 1);
`endif
endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: directed self-checking bench for uart_xcvr (default DUT plus an even-parity DUT).
module tb_uart_xcvr;
    logic clk = 0;
    always #50 clk = ~clk;

    logic       rst = 1, tx_dv = 0, rx_a = 1, rd_a = 0, rx_b = 1, rd_b = 0, tx_dv_b = 0;
    logic [7:0] tx_byte = 0, tx_byte_b = 0;
    logic       tx_active, tx_serial, tx_done, rx_dv, perr, ferr, ovr;
    logic [7:0] rx_byte;
    logic       b_active, b_serial, b_done, b_dv, b_perr, b_ferr, b_ovr;
    logic [7:0] b_byte;

    uart_xcvr dut (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv), .i_Tx_Byte(tx_byte),
        .o_Tx_Active(tx_active), .o_Tx_Serial(tx_serial), .o_Tx_Done(tx_done),
        .i_Rx_Serial(rx_a), .i_Rx_Rd(rd_a), .o_Rx_DV(rx_dv), .o_Rx_Byte(rx_byte),
        .o_Rx_Parity_Err(perr), .o_Rx_Frame_Err(ferr), .o_Rx_Overrun(ovr)
    );

    uart_xcvr #(.PARITY_MODE(2)) dut_p (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(tx_dv_b), .i_Tx_Byte(tx_byte_b),
        .o_Tx_Active(b_active), .o_Tx_Serial(b_serial), .o_Tx_Done(b_done),
        .i_Rx_Serial(rx_b), .i_Rx_Rd(rd_b), .o_Rx_DV(b_dv), .o_Rx_Byte(b_byte),
        .o_Rx_Parity_Err(b_perr), .o_Rx_Frame_Err(b_ferr), .o_Rx_Overrun(b_ovr)
    );

    int checks = 0, failures = 0;
    int done_cnt = 0, ovr_cnt = 0, dv_a = 0, dv_b = 0, seen_a = 0, seen_b = 0;
    logic [9:0] cap_a = 0, cap_b = 0;

    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (ovr) ovr_cnt <= ovr_cnt + 1;
        if (rx_dv) begin
            dv_a  <= dv_a + 1;
            cap_a <= {rx_byte, perr, ferr};
        end
        if (b_dv) begin
            dv_b  <= dv_b + 1;
            cap_b <= {b_byte, b_perr, b_ferr};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit which, input logic v);
        if (which) rx_b = v;
        else rx_a = v;
    endtask

    task automatic send(input bit which, input logic [7:0] b, input bit par_en, input bit par, input bit stop);
        set_line(which, 1'b0);
        #8700;
        for (int i = 0; i < 8; i++) begin
            set_line(which, b[i]);
            #8700;
        end
        if (par_en) begin
            set_line(which, par);
            #8700;
        end
        set_line(which, stop);
        #8700;
        set_line(which, 1'b1);
        ticks(10);
    endtask

    // Fetch one received frame: n is how many cycles o_Rx_DV was seen high (pulse mode)
    // or whether the FIFO head was valid (FIFO mode, which also pops it).
    task automatic get(input bit which, output logic [9:0] w, output int n);
`ifdef UART_RX_FIFO_EN
        n = which ? int'(b_dv) : int'(rx_dv);
        w = which ? {b_byte, b_perr, b_ferr} : {rx_byte, perr, ferr};
        if (n != 0) begin
            if (which) rd_b = 1;
            else rd_a = 1;
            ticks(1);
            rd_a = 0;
            rd_b = 0;
        end
`else
        n = which ? dv_b - seen_b : dv_a - seen_a;
        w = which ? cap_b : cap_a;
        seen_a = dv_a;
        seen_b = dv_b;
`endif
    endtask

    task automatic expect_frame(input bit which, input string tag, input logic [7:0] b, input logic pe, input logic fe);
        logic [9:0] w;
        int n;
        get(which, w, n);
        check({tag, " dv"}, n, 1);
        check({tag, " word"}, {22'd0, w}, {22'd0, b, pe, fe});
    endtask

    task automatic expect_none(input bit which, input string tag);
        logic [9:0] w;
        int n;
        get(which, w, n);
        check({tag, " no dv"}, n, 0);
    endtask

    initial begin
        logic [9:0] fr;
        ticks(3);
        check("rst tx_serial", tx_serial, 1);
        check("rst tx_active", tx_active, 0);
        check("rst tx_done", tx_done, 0);
        check("rst rx_dv", rx_dv, 0);
        check("rst rx_byte", rx_byte, 0);
        check("rst perr", perr, 0);
        check("rst ferr", ferr, 0);
        check("rst overrun", ovr, 0);
        rst = 0;
        ticks(2);

        // 8'hAB: start 0, data LSB first 1,1,0,1,0,1,0,1, stop 1; checked at first and last cycle of each bit
        fr = {1'b1, 8'hAB, 1'b0};
        tx_byte = 8'hAB;
        tx_dv = 1;
        ticks(1);
        tx_dv = 0;
        check("tx active start", tx_active, 1);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx bit%0d first", k), tx_serial, fr[k]);
            ticks(86);
            check($sformatf("tx bit%0d last", k), tx_serial, fr[k]);
            if (k == 9) check("tx active last stop", tx_active, 1);
            ticks(1);
        end
        check("tx done cleanup", tx_done, 1);
        check("tx active cleanup", tx_active, 0);
        ticks(1);
        check("tx done one cycle", tx_done, 0);
        check("tx done count", done_cnt, 1);

        // back-to-back request of 8'h00, then a request while busy, then reset mid-frame
        tx_byte = 8'h00;
        tx_dv = 1;
        ticks(1);
        tx_dv = 0;
        check("b2b start", tx_serial, 0);
        check("b2b active", tx_active, 1);
        ticks(100);
        tx_byte = 8'hFF;
        tx_dv = 1;
        ticks(1);
        tx_dv = 0;
        ticks(86);
        check("busy dv ignored", tx_serial, 0);
        rst = 1;
        ticks(1);
        rst = 0;
        check("mid rst serial", tx_serial, 1);
        check("mid rst active", tx_active, 0);
        ticks(1000);
        check("mid rst no done", done_cnt, 1);
        check("mid rst idle", tx_serial, 1);

        send(0, 8'h3F, 0, 0, 1);
        expect_frame(0, "rx 3f", 8'h3F, 0, 0);
`ifndef UART_RX_FIFO_EN
        check("rx dv pulse low", rx_dv, 0);
        check("rx byte held", rx_byte, 8'h3F);
`else
        check("rx popped empty", rx_dv, 0);
`endif

        rx_a = 0;
        #2000;
        rx_a = 1;
        #20000;
        ticks(1);
        expect_none(0, "glitch");

        send(0, 8'h55, 0, 0, 0);
        expect_frame(0, "rx 55 ferr", 8'h55, 0, 1);

        send(1, 8'h07, 1, 0, 1);
        expect_frame(1, "par 07 bad", 8'h07, 1, 0);
        send(1, 8'h03, 1, 0, 1);
        expect_frame(1, "par 03 good", 8'h03, 0, 0);

`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 4; i++) send(0, 8'(i), 0, 0, 1);
        check("fifo no ovr yet", ovr_cnt, 0);
        send(0, 8'h05, 0, 0, 1);
        check("fifo ovr pulse", ovr_cnt, 1);
        for (int i = 1; i <= 4; i++) expect_frame(0, $sformatf("fifo pop%0d", i), 8'(i), 0, 0);
        expect_none(0, "fifo drained");
`else
        check("no overrun ever", ovr_cnt, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
